// File: rtl/miner_ctrl_pkg.sv
// Shared types and constants for the bitcoin_miner host-side job controller.
package miner_ctrl_pkg;

    localparam int JOB_BYTES = 84;
    localparam int RES_BYTES = 5;
    localparam int JOB_BITS  = JOB_BYTES * 8;

    // Field placement inside the fully assembled 672-bit job register
    localparam int HASH_LSB = 416;
    localparam int HASH_W   = 256;
    localparam int SBLK_LSB = 288;
    localparam int SBLK_W   = 128;
    localparam int TGT_LSB  = 32;
    localparam int TGT_W    = 256;
    localparam int MAXN_LSB = 0;
    localparam int MAXN_W   = 32;

    localparam logic [7:0] STATUS_EXHAUSTED = 8'h00;
    localparam logic [7:0] STATUS_FOUND     = 8'h01;
    localparam logic [7:0] STATUS_NO_START  = 8'h02;

    typedef enum logic [2:0] {
        LOAD,
        START,
        ARM,
        RUN,
        SEND
    } ctrlState_e;

    // Result frame byte 1..4 carries the nonce MSB first; anything else is zero
    function automatic logic [7:0] nonceByte(input logic [31:0] nonce, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd1:    b = nonce[31:24];
            3'd2:    b = nonce[23:16];
            3'd3:    b = nonce[15:8];
            3'd4:    b = nonce[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/job_shift_reg.sv
// Byte-wide job assembly register; every shifted byte enters at the LSB so the
// first byte of the frame ends up in the most significant position.
module job_shift_reg
    import miner_ctrl_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         shiftEn_i,
    input  logic [7:0]   data_i,
    output logic [255:0] hash_o,
    output logic [127:0] secondBlock_o,
    output logic [255:0] target_o,
    output logic [31:0]  maxNonce_o
);

    logic [JOB_BITS-1:0] job_q;

    // Shift one byte in per enabled cycle, otherwise hold the assembled job
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            job_q <= '0;
        end else if (shiftEn_i) begin
            job_q <= {job_q[JOB_BITS-9:0], data_i};
        end
    end

    assign hash_o        = job_q[HASH_LSB +: HASH_W];
    assign secondBlock_o = job_q[SBLK_LSB +: SBLK_W];
    assign target_o      = job_q[TGT_LSB +: TGT_W];
    assign maxNonce_o    = job_q[MAXN_LSB +: MAXN_W];

endmodule

// File: rtl/miner_job_controller.sv
// Host-side initiator for bitcoin_miner: loads an 84-byte job, starts the miner,
// watches running/found and streams back a 5-byte status + nonce frame.
module miner_job_controller
    import miner_ctrl_pkg::*;
#(
    parameter int ARM_TIMEOUT = 16
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         miner_start,
    output logic [255:0] miner_first_block_hash,
    output logic [127:0] miner_second_block,
    output logic [255:0] miner_target,
    output logic [31:0]  miner_max_nonce,
    input  logic         miner_running,
    input  logic         miner_found,
    input  logic [31:0]  miner_nonce,
    output logic         busy
);

    localparam int TO_W = $clog2(ARM_TIMEOUT + 1);

    ctrlState_e      state_q, state_d;
    logic [6:0]      byteCnt_q, byteCnt_d;
    logic [2:0]      outCnt_q, outCnt_d;
    logic [TO_W-1:0] toCnt_q, toCnt_d;
    logic            foundSeen_q, foundSeen_d;
    logic [31:0]     nonce_q, nonce_d;
    logic [7:0]      status_q, status_d;
    logic            shiftEn;

    job_shift_reg u_jobReg (
        .clk_i         (clk),
        .rst_i         (rst),
        .shiftEn_i     (shiftEn),
        .data_i        (in_data),
        .hash_o        (miner_first_block_hash),
        .secondBlock_o (miner_second_block),
        .target_o      (miner_target),
        .maxNonce_o    (miner_max_nonce)
    );

    // Control state, counters and result latches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            byteCnt_q   <= '0;
            outCnt_q    <= '0;
            toCnt_q     <= '0;
            foundSeen_q <= 1'b0;
            nonce_q     <= '0;
            status_q    <= STATUS_EXHAUSTED;
        end else begin
            state_q     <= state_d;
            byteCnt_q   <= byteCnt_d;
            outCnt_q    <= outCnt_d;
            toCnt_q     <= toCnt_d;
            foundSeen_q <= foundSeen_d;
            nonce_q     <= nonce_d;
            status_q    <= status_d;
        end
    end

    // Next-state and output decode for the job/result sequence
    always_comb begin
        state_d     = state_q;
        byteCnt_d   = byteCnt_q;
        outCnt_d    = outCnt_q;
        toCnt_d     = toCnt_q;
        foundSeen_d = foundSeen_q;
        nonce_d     = nonce_q;
        status_d    = status_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = 8'h00;
        miner_start = 1'b0;
        shiftEn     = 1'b0;

        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shiftEn = 1'b1;
                    if (byteCnt_q == 7'(JOB_BYTES - 1)) begin
                        byteCnt_d = '0;
                        state_d   = START;
                    end else begin
                        byteCnt_d = byteCnt_q + 7'd1;
                    end
                end
            end

            START: begin
                miner_start = 1'b1;
                foundSeen_d = 1'b0;
                toCnt_d     = '0;
                nonce_d     = '0;
                outCnt_d    = '0;
                status_d    = STATUS_EXHAUSTED;
                state_d     = ARM;
            end

            ARM: begin
                if (toCnt_q != TO_W'(ARM_TIMEOUT)) begin
                    toCnt_d = toCnt_q + 1'b1;
                end
                if (miner_running) begin
                    state_d = RUN;
                end else if (toCnt_d == TO_W'(ARM_TIMEOUT)) begin
                    status_d = STATUS_NO_START;
                    state_d  = SEND;
                end
            end

            RUN: begin
                if (miner_found) begin
                    foundSeen_d = 1'b1;
                    nonce_d     = miner_nonce;
                end
                if (!miner_running) begin
                    status_d = (foundSeen_q || miner_found) ? STATUS_FOUND : STATUS_EXHAUSTED;
                    outCnt_d = '0;
                    state_d  = SEND;
                end
            end

            SEND: begin
                out_valid = 1'b1;
                if (outCnt_q == 3'd0) begin
                    out_data = status_q;
                end else if (status_q == STATUS_FOUND) begin
                    out_data = nonceByte(nonce_q, outCnt_q);
                end
                if (out_ready) begin
                    if (outCnt_q == 3'(RES_BYTES - 1)) begin
                        outCnt_d = '0;
                        state_d  = LOAD;
                    end else begin
                        outCnt_d = outCnt_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign busy = (state_q != LOAD);

endmodule

// File: tb/tb_miner_job_controller.sv
// Directed self-checking bench for miner_job_controller with a scripted miner.
module tb_miner_job_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         miner_start;
    logic [255:0] miner_first_block_hash;
    logic [127:0] miner_second_block;
    logic [255:0] miner_target;
    logic [31:0]  miner_max_nonce;
    logic         miner_running;
    logic         miner_found;
    logic [31:0]  miner_nonce;
    logic         busy;

    int testsRun    = 0;
    int testsFailed = 0;
    int startCount  = 0;

    localparam logic [255:0] HASH_A = 256'hb9f7a3c6_08fd99ee_77e11ba5_1b486aa5_a23a9b2a_0518fb23_c8099145_2cc89bdb;
    localparam logic [127:0] SBLK_A = 128'h1548730c_d398af5b_1f5a2717_7337f2f4;
    localparam logic [255:0] TGT_A  = 256'h00000000_ffff0000_00000000_00000000_00000000_00000000_00000000_0000172a;
    localparam logic [31:0]  MAXN_A = 32'hffffffff;

    localparam logic [255:0] HASH_B = 256'h01234567_89abcdef_fedcba98_76543210_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    localparam logic [127:0] SBLK_B = 128'hcafef00d_12345678_9abcdef0_0badc0de;
    localparam logic [255:0] TGT_B  = 256'h00000000_00000000_0000ffff_00000000_00000000_00000000_00000000_00000000;
    localparam logic [31:0]  MAXN_B = 32'h00001000;

    miner_job_controller #(.ARM_TIMEOUT(16)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .in_data                (in_data),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .out_data               (out_data),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .miner_start            (miner_start),
        .miner_first_block_hash (miner_first_block_hash),
        .miner_second_block     (miner_second_block),
        .miner_target           (miner_target),
        .miner_max_nonce        (miner_max_nonce),
        .miner_running          (miner_running),
        .miner_found            (miner_found),
        .miner_nonce            (miner_nonce),
        .busy                   (busy)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Count every cycle the start pulse is seen by the miner
    always @(posedge clk) begin
        if (miner_start === 1'b1) startCount++;
    end

    // Hard stop if the sequence ever wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkBuses(input string tag, input logic [255:0] h, input logic [127:0] sb,
                              input logic [255:0] tg, input logic [31:0] mn);
        checkOutput({tag, "Hash"}, miner_first_block_hash, h);
        checkOutput({tag, "SecondBlock"}, {128'h0, miner_second_block}, {128'h0, sb});
        checkOutput({tag, "Target"}, miner_target, tg);
        checkOutput({tag, "MaxNonce"}, {224'h0, miner_max_nonce}, {224'h0, mn});
    endtask

    // Called at a negedge; sends nBytes of the job frame. A full frame returns at the first ARM negedge.
    task automatic applyStimulus(input logic [255:0] h, input logic [127:0] sb,
                                 input logic [255:0] tg, input logic [31:0] mn, input int nBytes);
        logic [671:0] frame;
        int startBefore;
        frame = {h, sb, tg, mn};
        startBefore = startCount;
        for (int i = 0; i < nBytes; i++) begin
            in_valid = 1'b1;
            in_data  = frame[671 - 8*i -: 8];
            if (i == 0 || i == 83) checkOutput("inReadyLoad", in_ready, 1);
            if (i == 83) checkOutput("noEarlyStart", startCount, startBefore);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        if (nBytes == 84) begin
            checkOutput("startPulse", miner_start, 1);
            checkOutput("inReadyStart", in_ready, 0);
            @(negedge clk);
            checkOutput("startOneCycle", miner_start, 0);
            checkOutput("startCount", startCount, startBefore + 1);
            checkOutput("inReadyArm", in_ready, 0);
        end
    endtask

    // Called at a negedge; waits (bounded) for the result frame and checks all 5 bytes
    task automatic receiveResult(input logic [39:0] expFrame, input bit stall, output int waitCycles);
        logic [7:0] expByte;
        int n;
        waitCycles = 0;
        in_valid = 1'b1;
        in_data  = 8'h5a;
        while (out_valid !== 1'b1 && waitCycles < 40) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("outValidSeen", out_valid, 1);
        if (out_valid === 1'b1) begin
            for (int b = 0; b < 5; b++) begin
                expByte = expFrame[39 - 8*b -: 8];
                if (stall) begin
                    n = $urandom_range(1, 3);
                    out_ready = 1'b0;
                    repeat (n) begin
                        checkOutput($sformatf("holdByte%0d", b), out_data, expByte);
                        checkOutput("holdValid", out_valid, 1);
                        @(negedge clk);
                    end
                end
                out_ready = 1'b1;
                checkOutput($sformatf("resultByte%0d", b), out_data, expByte);
                checkOutput("inReadySend", in_ready, 0);
                @(negedge clk);
                out_ready = 1'b0;
                if (b == 4) in_valid = 1'b0;
            end
            checkOutput("outValidDone", out_valid, 0);
            checkOutput("inReadyDone", in_ready, 1);
            checkOutput("busyDone", busy, 0);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Directed scenario sequence
    initial begin
        int waitCycles;
        rst           = 1'b1;
        in_data       = 8'h00;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        miner_running = 1'b0;
        miner_found   = 1'b0;
        miner_nonce   = 32'h0;

        repeat (2) @(negedge clk);
        checkOutput("rstInReady", in_ready, 1);
        checkOutput("rstOutValid", out_valid, 0);
        checkOutput("rstOutData", out_data, 0);
        checkOutput("rstStart", miner_start, 0);
        checkOutput("rstBusy", busy, 0);
        checkBuses("rst", 256'h0, 128'h0, 256'h0, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idleInReady", in_ready, 1);

        // Found then running falls: 01 15 48 73 0c, with random output stalls
        applyStimulus(HASH_A, SBLK_A, TGT_A, MAXN_A, 84);
        checkBuses("jobA", HASH_A, SBLK_A, TGT_A, MAXN_A);
        miner_running = 1'b1;
        @(negedge clk);
        checkOutput("busyRun", busy, 1);
        checkOutput("inReadyRun", in_ready, 0);
        miner_found = 1'b1;
        miner_nonce = 32'h1548730c;
        @(negedge clk);
        miner_found = 1'b0;
        miner_nonce = 32'hffff0000;
        @(negedge clk);
        miner_running = 1'b0;
        @(negedge clk);
        receiveResult(40'h01_1548730c, 1'b1, waitCycles);
        checkBuses("jobAHeld", HASH_A, SBLK_A, TGT_A, MAXN_A);

        // Running falls without found: all-zero frame
        applyStimulus(HASH_A, SBLK_A, TGT_A, MAXN_A, 84);
        miner_running = 1'b1;
        @(negedge clk);
        miner_nonce = 32'h12345678;
        @(negedge clk);
        miner_running = 1'b0;
        @(negedge clk);
        receiveResult(40'h00_00000000, 1'b0, waitCycles);

        // Miner never runs: status 02 after exactly 16 ARM cycles
        applyStimulus(HASH_A, SBLK_A, TGT_A, MAXN_A, 84);
        miner_nonce = 32'hcafebabe;
        receiveResult(40'h02_00000000, 1'b0, waitCycles);
        checkOutput("armTimeoutCycles", waitCycles, 16);

        // Reset after 40 job bytes abandons the frame
        applyStimulus(HASH_A, SBLK_A, TGT_A, MAXN_A, 40);
        rst = 1'b1;
        #1;
        checkOutput("midRstInReady", in_ready, 1);
        checkOutput("midRstBusy", busy, 0);
        checkBuses("midRst", 256'h0, 128'h0, 256'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        miner_running = 1'b1;
        miner_found   = 1'b1;
        @(negedge clk);
        checkOutput("loadIgnoresMiner", busy, 0);
        checkOutput("loadInReady", in_ready, 1);
        miner_running = 1'b0;
        miner_found   = 1'b0;
        @(negedge clk);

        // Fresh job, found coincides with running falling: 01 de ad be ef
        applyStimulus(HASH_B, SBLK_B, TGT_B, MAXN_B, 84);
        checkBuses("jobB", HASH_B, SBLK_B, TGT_B, MAXN_B);
        miner_running = 1'b1;
        @(negedge clk);
        @(negedge clk);
        miner_found   = 1'b1;
        miner_nonce   = 32'hdeadbeef;
        miner_running = 1'b0;
        @(negedge clk);
        miner_found = 1'b0;
        miner_nonce = 32'h0;
        receiveResult(40'h01_deadbeef, 1'b1, waitCycles);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/miner_job_controller.md
Name: miner_job_controller

Overview:
- Host-side initiator for the bitcoin_miner job interface.
- Receives a job as an 84-byte stream over valid/ready and assembles the miner operand buses.
- Pulses miner_start, tracks miner_running and miner_found, then returns a 5-byte result frame (status + nonce) over a second valid/ready byte stream.
- Sits between the UART/host byte link and bitcoin_miner.

Parameters:
- ARM_TIMEOUT, 16, cycles after miner_start to wait for miner_running to rise before reporting an error.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  asynchronous active-high reset
- in_data  input  8  job byte
- in_valid  input  1  job byte valid
- in_ready  output  1  controller accepts byte (transfer = in_valid & in_ready)
- out_data  output  8  result byte
- out_valid  output  1  result byte valid
- out_ready  input  1  host accepts result byte
- miner_start  output  1  one-cycle start pulse to miner
- miner_first_block_hash  output  256  midstate of first block
- miner_second_block  output  128  second-block header tail
- miner_target  output  256  hash target (exclusive bound)
- miner_max_nonce  output  32  last nonce to try
- miner_running  input  1  miner busy
- miner_found  input  1  miner found a nonce
- miner_nonce  input  32  nonce, valid while miner_found=1
- busy  output  1  high in every state except LOAD

Behaviour:
- Reset (async, any state): state=LOAD, byte_cnt=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, miner_start=0, busy=0.
  - All miner operand buses and the nonce/found latches cleared to 0.
- Job frame: 84 bytes, each field MSB byte first.
  - Bytes 0-31: first_block_hash.
  - Bytes 32-47: second_block.
  - Bytes 48-79: target.
  - Bytes 80-83: max_nonce.
- Assembly: 672-bit shift register; each accepted byte shifts in at the LSB.
  - After byte 83 the fields map directly: [671:416] hash, [415:288] second_block, [287:32] target, [31:0] max_nonce.
  - Operand buses drive from this register and stay stable from START until the next LOAD byte is accepted.
- LOAD: in_ready=1. Count accepted bytes. On the 84th accepted byte: byte_cnt->0, in_ready->0 next cycle, go to START.
- START: miner_start=1 for exactly one cycle; clear found_seen and the timeout counter; go to ARM.
- ARM: in_ready=0. Increment the timeout counter each cycle.
  - miner_running=1 -> RUN.
  - Counter reaches ARM_TIMEOUT with running still 0 -> status=0x02, go to SEND.
- RUN: on any cycle with miner_found=1, set found_seen and capture miner_nonce (last capture wins).
  - Capture logic is also active in the cycle running falls.
  - On miner_running=0 -> status = found_seen (or miner_found this cycle) ? 0x01 : 0x00, go to SEND.
  - Same-cycle found and running-fall counts as found, with that cycle's nonce.
- SEND: 5 bytes, out_valid=1 throughout.
  - Byte 0: status. Bytes 1-4: nonce, MSB first. Nonce = 0 when status != 0x01.
  - Advance one byte per cycle with out_valid & out_ready. Hold out_data stable while out_ready=0.
  - After byte 4 is accepted: out_valid=0, return to LOAD next cycle.
- Back-pressure: in_ready=0 in START/ARM/RUN/SEND. Bytes offered then are not consumed; no overrun is possible.
- Widths: byte_cnt 7 bits (0..83). out_cnt 3 bits (0..4). Timeout counter is $clog2(ARM_TIMEOUT+1) bits and saturates.
- rst asserted mid-job or mid-SEND aborts immediately; partial frames are discarded. The miner is not aborted, and its later running/found are ignored while in LOAD.

Decomposition:
- Package miner_ctrl_pkg: state enum (LOAD, START, ARM, RUN, SEND), JOB_BYTES=84, RES_BYTES=5, field offsets, status codes (0x00 exhausted, 0x01 found, 0x02 no-start).
- Sub-module job_shift_reg: 672-bit byte-wide shift register with async reset, shift enable and 8-bit input. It provides the four field slices.

Test Plan:
- Job hash=b9f7a3c608fd99ee77e11ba51b486aa5a23a9b2a0518fb23c80991452cc89bdb, second_block=1548730cd398af5b1f5a27177337f2f4-09000000, target=...1729+1, max_nonce=ffffffff.
  - Required: exactly one miner_start pulse the cycle after byte 83.
  - Required: buses equal the loaded values.
  - Required: in_ready=0 until the result completes.
- Behavioural miner model asserts found with nonce 0x1548730c, then drops running -> out bytes 01,15,48,73,0c.
- Model drops running without found -> 00,00,00,00,00.
- Model never raises running -> status 0x02 after 16 ARM cycles, nonce bytes 0.
- found and running-fall in the same cycle with nonce 0xdeadbeef -> 01,de,ad,be,ef.
- Random out_ready stalls keep out_data stable.
- rst pulse after 40 job bytes -> in_ready=1, byte_cnt=0, no start. A fresh 84-byte job then runs correctly.
